// File: rtl/mem_access_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_seq_if
// Brief    : Request/grant handshake and datapath strobes of mem_access_seq.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_access_seq_if;
   logic fetch_req;
   logic data_req;
   logic data_we;
   logic fetch_gnt;
   logic data_gnt;
   logic fetch_done;
   logic data_done;
   logic addr_phase;
   logic wdata_phase;
   logic data_drive;
   logic PCout;
   logic IncPC;
   logic MARin;
   logic MDRin;
   logic MDRread;
   logic memWrite;
   logic MDRout;
   logic IRin;

   // The sequencer side.
   modport slave (
      input  fetch_req, data_req, data_we,
      output fetch_gnt, data_gnt, fetch_done, data_done,
      output addr_phase, wdata_phase, data_drive,
      output PCout, IncPC, MARin, MDRin, MDRread, memWrite, MDRout, IRin
   );

   // The requester / datapath side.
   modport master (
      output fetch_req, data_req, data_we,
      input  fetch_gnt, data_gnt, fetch_done, data_done,
      input  addr_phase, wdata_phase, data_drive,
      input  PCout, IncPC, MARin, MDRin, MDRread, memWrite, MDRout, IRin
   );
endinterface
`default_nettype wire

// File: rtl/mem_access_seq.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_seq
// Brief    : MAR/MDR/memory access sequencer arbitrating fetch and ld/st.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_seq #(
   parameter int WAIT_CYC    = 2,
   parameter bit ROUND_ROBIN = 1'b1
) (
   input  logic              clk,
   input  logic              clr,
   mem_access_seq_if.slave   bus
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ADDR  = 3'd1,
      S_WDATA = 3'd2,
      S_MEM   = 3'd3,
      S_CAPT  = 3'd4,
      S_DRIVE = 3'd5
   } state_t;

   localparam logic [3:0] c_CNT_INIT = 4'(WAIT_CYC - 1);

   state_t     r_state;
   logic [3:0] r_cnt;
   logic       r_who;        // 1 = data access owns the sequence
   logic       r_we;
   logic       r_last_data;

   logic r_fetch_gnt, r_data_gnt, r_fetch_done, r_data_done;
   logic r_addr_phase, r_wdata_phase, r_data_drive;
   logic r_pcout, r_incpc, r_marin, r_mdrin, r_mdrread, r_memwrite, r_mdrout, r_irin;

   logic w_tie_data;
   logic w_pick_data;
   logic w_store;

   assign w_tie_data  = ROUND_ROBIN ? ~r_last_data : 1'b1;
   assign w_pick_data = bus.data_req & (~bus.fetch_req | w_tie_data);
   assign w_store     = r_who & r_we;

   // Outputs are registered alongside the state they belong to, so each
   // transition below loads the decode of the state being entered.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_state       <= S_IDLE;
         r_cnt         <= 4'd0;
         r_who         <= 1'b0;
         r_we          <= 1'b0;
         r_last_data   <= 1'b1;
         r_fetch_gnt   <= 1'b0;
         r_data_gnt    <= 1'b0;
         r_fetch_done  <= 1'b0;
         r_data_done   <= 1'b0;
         r_addr_phase  <= 1'b0;
         r_wdata_phase <= 1'b0;
         r_data_drive  <= 1'b0;
         r_pcout       <= 1'b0;
         r_incpc       <= 1'b0;
         r_marin       <= 1'b0;
         r_mdrin       <= 1'b0;
         r_mdrread     <= 1'b0;
         r_memwrite    <= 1'b0;
         r_mdrout      <= 1'b0;
         r_irin        <= 1'b0;
      end else begin
         r_fetch_gnt   <= 1'b0;
         r_data_gnt    <= 1'b0;
         r_fetch_done  <= 1'b0;
         r_data_done   <= 1'b0;
         r_addr_phase  <= 1'b0;
         r_wdata_phase <= 1'b0;
         r_data_drive  <= 1'b0;
         r_pcout       <= 1'b0;
         r_incpc       <= 1'b0;
         r_marin       <= 1'b0;
         r_mdrin       <= 1'b0;
         r_mdrread     <= 1'b0;
         r_memwrite    <= 1'b0;
         r_mdrout      <= 1'b0;
         r_irin        <= 1'b0;

         case (r_state)
            S_IDLE: begin
               if (bus.fetch_req | bus.data_req) begin
                  r_state      <= S_ADDR;
                  r_who        <= w_pick_data;
                  r_we         <= w_pick_data & bus.data_we;
                  r_last_data  <= w_pick_data;
                  r_marin      <= 1'b1;
                  r_fetch_gnt  <= ~w_pick_data;
                  r_data_gnt   <= w_pick_data;
                  r_pcout      <= ~w_pick_data;
                  r_incpc      <= ~w_pick_data;
                  r_addr_phase <= w_pick_data;
               end
            end

            S_ADDR: begin
               r_fetch_gnt <= ~r_who;
               r_data_gnt  <= r_who;
               if (w_store) begin
                  r_state       <= S_WDATA;
                  r_mdrin       <= 1'b1;
                  r_wdata_phase <= 1'b1;
               end else begin
                  r_state <= S_MEM;
                  r_cnt   <= c_CNT_INIT;
               end
            end

            S_WDATA: begin
               r_state     <= S_MEM;
               r_cnt       <= c_CNT_INIT;
               r_data_gnt  <= 1'b1;
               r_memwrite  <= 1'b1;
               r_data_done <= (c_CNT_INIT == 4'd0);
            end

            S_MEM: begin
               if (r_cnt == 4'd0) begin
                  // A store finishes in its last MEM cycle; loads/fetches capture.
                  if (w_store) begin
                     r_state <= S_IDLE;
                  end else begin
                     r_state     <= S_CAPT;
                     r_fetch_gnt <= ~r_who;
                     r_data_gnt  <= r_who;
                     r_mdrread   <= 1'b1;
                     r_mdrin     <= 1'b1;
                  end
               end else begin
                  r_cnt       <= r_cnt - 4'd1;
                  r_fetch_gnt <= ~r_who;
                  r_data_gnt  <= r_who;
                  r_memwrite  <= w_store;
                  r_data_done <= w_store & (r_cnt == 4'd1);
               end
            end

            S_CAPT: begin
               r_state      <= S_DRIVE;
               r_fetch_gnt  <= ~r_who;
               r_data_gnt   <= r_who;
               r_mdrout     <= 1'b1;
               r_irin       <= ~r_who;
               r_data_drive <= r_who;
               r_fetch_done <= ~r_who;
               r_data_done  <= r_who;
            end

            S_DRIVE: begin
               r_state <= S_IDLE;
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.fetch_gnt   = r_fetch_gnt;
   assign bus.data_gnt    = r_data_gnt;
   assign bus.fetch_done  = r_fetch_done;
   assign bus.data_done   = r_data_done;
   assign bus.addr_phase  = r_addr_phase;
   assign bus.wdata_phase = r_wdata_phase;
   assign bus.data_drive  = r_data_drive;
   assign bus.PCout       = r_pcout;
   assign bus.IncPC       = r_incpc;
   assign bus.MARin       = r_marin;
   assign bus.MDRin       = r_mdrin;
   assign bus.MDRread     = r_mdrread;
   assign bus.memWrite    = r_memwrite;
   assign bus.MDRout      = r_mdrout;
   assign bus.IRin        = r_irin;

endmodule
`default_nettype wire
